// File: rtl/color_sensor_pkg.sv
// Shared constants for the colour-sensor blocks: channel indices, {S2,S3} filter codes, FSM encoding.
package color_sensor_pkg;
  localparam logic [1:0] CH_RED   = 2'd0;
  localparam logic [1:0] CH_GREEN = 2'd1;
  localparam logic [1:0] CH_BLUE  = 2'd2;
  localparam logic [1:0] CH_CLEAR = 2'd3;

  localparam logic [1:0] FLT_RED   = 2'b00;
  localparam logic [1:0] FLT_GREEN = 2'b11;
  localparam logic [1:0] FLT_BLUE  = 2'b01;
  localparam logic [1:0] FLT_CLEAR = 2'b10;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_GATE   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  function automatic logic [1:0] filter_code(input logic [1:0] ch);
    case (ch)
      CH_RED:   filter_code = FLT_RED;
      CH_GREEN: filter_code = FLT_GREEN;
      CH_BLUE:  filter_code = FLT_BLUE;
      default:  filter_code = FLT_CLEAR;
    endcase
  endfunction
endpackage

// File: rtl/freq_edge_sync.sv
// Two-flop synchroniser for the sensor frequency pin plus a registered rising-edge strobe.
module freq_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic strobe
);
  logic [2:0] sh;

  // Strobe is registered so it lands 3 clocks after the pin edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh     <= '0;
      strobe <= 1'b0;
    end else begin
      sh     <= {sh[1:0], pin};
      strobe <= sh[1] & ~sh[2];
    end
  end
endmodule

// File: rtl/color_channel_sampler.sv
// Colour-sensor sampler: settles each filter, counts averaged gate windows, publishes all channels at once.
module color_channel_sampler
  import color_sensor_pkg::*;
#(
  parameter int CNT_W         = 16,
  parameter int NUM_CH        = 4,
  parameter int GATE_CYCLES   = 1000000,
  parameter int SETTLE_CYCLES = 10000,
  parameter int AVG_LOG2      = 2
) (
  input  logic                    CLK100MHZ,
  input  logic                    reset,
  input  logic                    signal_in,
  input  logic                    start,
  input  logic                    continuous,
  output logic                    S2,
  output logic                    S3,
  output logic [NUM_CH*CNT_W-1:0] ch_data,
  output logic [NUM_CH-1:0]       ch_sat,
  output logic [1:0]              ch_index,
  output logic                    busy,
  output logic                    done_color
);
  localparam int NWIN = 1 << AVG_LOG2;
  localparam int TMAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int WW   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int AW   = CNT_W + AVG_LOG2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]                    state;
  logic [TW-1:0]                 timer;
  logic [WW-1:0]                 win;
  logic [CNT_W-1:0]              win_cnt;
  logic [AW-1:0]                 acc;
  logic [NUM_CH-1:0][CNT_W-1:0]  stage;
  logic [NUM_CH-1:0]             sat_stage;
  logic                          strobe;

  freq_edge_sync u_sync (.clk(CLK100MHZ), .rst(reset), .pin(signal_in), .strobe(strobe));

  logic             win_ovf, settle_end, gate_end, last_win, last_ch;
  logic [CNT_W-1:0] win_next;
  logic [AW-1:0]    acc_next;
  logic [1:0]       ch_next;

  // win_next includes a strobe arriving in the final gate clock.
  assign win_ovf    = strobe && (win_cnt == CNT_MAX);
  assign win_next   = (strobe && !win_ovf) ? win_cnt + 1'b1 : win_cnt;
  assign acc_next   = acc + AW'(win_next);
  assign settle_end = (timer == TW'(SETTLE_CYCLES - 1));
  assign gate_end   = (timer == TW'(GATE_CYCLES - 1));
  assign last_win   = (win == WW'(NWIN - 1));
  assign last_ch    = (ch_index == 2'(NUM_CH - 1));
  assign ch_next    = ch_index + 2'd1;
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      timer      <= '0;
      win        <= '0;
      win_cnt    <= '0;
      acc        <= '0;
      stage      <= '0;
      sat_stage  <= '0;
      ch_index   <= CH_RED;
      {S2, S3}   <= FLT_RED;
      ch_data    <= '0;
      ch_sat     <= '0;
      done_color <= 1'b0;
    end else begin
      done_color <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_SETTLE;
            timer     <= '0;
            ch_index  <= CH_RED;
            {S2, S3}  <= FLT_RED;
            sat_stage <= '0;
            acc       <= '0;
          end
        end
        ST_SETTLE: begin
          if (settle_end) begin
            state   <= ST_GATE;
            timer   <= '0;
            win     <= '0;
            win_cnt <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_GATE: begin
          if (win_ovf) sat_stage[ch_index] <= 1'b1;
          if (!gate_end) begin
            timer   <= timer + 1'b1;
            win_cnt <= win_next;
          end else begin
            timer   <= '0;
            win_cnt <= '0;
            if (!last_win) begin
              acc <= acc_next;
              win <= win + 1'b1;
            end else begin
              acc             <= '0;
              win             <= '0;
              stage[ch_index] <= CNT_W'(acc_next >> AVG_LOG2);
              if (!last_ch) begin
                ch_index <= ch_next;
                {S2, S3} <= filter_code(ch_next);
                state    <= ST_SETTLE;
              end else begin
                state <= ST_DONE;
              end
            end
          end
        end
        default: begin
          ch_data    <= stage;
          ch_sat     <= sat_stage;
          done_color <= 1'b1;
          ch_index   <= CH_RED;
          {S2, S3}   <= FLT_RED;
          timer      <= '0;
          acc        <= '0;
          sat_stage  <= '0;
          state      <= continuous ? ST_SETTLE : ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_color_channel_sampler.sv
// Bench for color_channel_sampler: three parameterisations driven by a filter-keyed square-wave sensor model.
module tb_color_channel_sampler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0] sig = '0, start_v = '0, cont_v = '0;
  logic [2:0] s2, s3, busy_v, done_v;
  logic [31:0] data_a;
  logic [19:0] data_b;
  logic [23:0] data_c;
  logic [3:0]  sat_a, sat_b;
  logic [2:0]  sat_c;
  logic [1:0]  idx_a, idx_b, idx_c;
  logic [1:0]  code [3];

  color_channel_sampler #(.CNT_W(8), .NUM_CH(4), .GATE_CYCLES(100), .SETTLE_CYCLES(10), .AVG_LOG2(1)) dut_a (
    .CLK100MHZ(clk), .reset(rst), .signal_in(sig[0]), .start(start_v[0]), .continuous(cont_v[0]),
    .S2(s2[0]), .S3(s3[0]), .ch_data(data_a), .ch_sat(sat_a), .ch_index(idx_a),
    .busy(busy_v[0]), .done_color(done_v[0]));
  color_channel_sampler #(.CNT_W(5), .NUM_CH(4), .GATE_CYCLES(100), .SETTLE_CYCLES(10), .AVG_LOG2(1)) dut_b (
    .CLK100MHZ(clk), .reset(rst), .signal_in(sig[1]), .start(start_v[1]), .continuous(cont_v[1]),
    .S2(s2[1]), .S3(s3[1]), .ch_data(data_b), .ch_sat(sat_b), .ch_index(idx_b),
    .busy(busy_v[1]), .done_color(done_v[1]));
  color_channel_sampler #(.CNT_W(8), .NUM_CH(3), .GATE_CYCLES(100), .SETTLE_CYCLES(10), .AVG_LOG2(1)) dut_c (
    .CLK100MHZ(clk), .reset(rst), .signal_in(sig[2]), .start(start_v[2]), .continuous(cont_v[2]),
    .S2(s2[2]), .S3(s3[2]), .ch_data(data_c), .ch_sat(sat_c), .ch_index(idx_c),
    .busy(busy_v[2]), .done_color(done_v[2]));

  assign code[0] = {s2[0], s3[0]};
  assign code[1] = {s2[1], s3[1]};
  assign code[2] = {s2[2], s3[2]};

  int per [3][4];
  int ph  [3] = '{0, 0, 0};
  int divs [7] = '{2, 4, 5, 10, 20, 25, 50};
  int total = 0, passes = 0;
  logic seen_a10 = 1'b0, seen_c10 = 1'b0;

  function automatic int code2ch(input logic [1:0] c);
    case (c)
      2'b00:   return 0;
      2'b11:   return 1;
      2'b01:   return 2;
      default: return 3;
    endcase
  endfunction

  // Sensor: square wave whose period is chosen by the filter code currently on S2/S3.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int p;
      p = per[i][code2ch(code[i])];
      ph[i] = ph[i] + 1;
      if (ph[i] >= p) ph[i] = 0;
      sig[i] = (ph[i] < p / 2);
    end
  end

  always @(posedge clk) begin
    if (code[0] == 2'b10) seen_a10 = 1'b1;
    if (code[2] == 2'b10) seen_c10 = 1'b1;
  end

  // Reference: edges per 100-clk window = 100/period, clamped at the counter max; averaging equal windows.
  function automatic logic [63:0] model_data(input int i, input int cw, input int nch);
    logic [63:0] d;
    d = '0;
    for (int ch = 0; ch < nch; ch++) begin
      longint e, mx;
      e  = 100 / per[i][ch];
      mx = (longint'(1) << cw) - 1;
      if (e > mx) e = mx;
      d = d | (64'(e) << (ch * cw));
    end
    return d;
  endfunction

  function automatic logic [63:0] model_sat(input int i, input int cw, input int nch);
    logic [63:0] s;
    s = '0;
    for (int ch = 0; ch < nch; ch++)
      if (100 / per[i][ch] > (1 << cw) - 1) s[ch] = 1'b1;
    return s;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic wait_done(input int i, output int n);
    n = 0;
    while (n < 2000) begin
      @(posedge clk); n++; #1;
      if (done_v[i]) break;
    end
  endtask

  task automatic run_pass(input int i, input int lat, input string tag);
    int n;
    @(negedge clk); start_v[i] = 1'b1;
    @(posedge clk); #1 start_v[i] = 1'b0;
    wait_done(i, n);
    chk({tag, "_lat"}, 64'(n), 64'(lat));
  endtask

  task automatic set_per(input int i, input int r, input int g, input int b, input int c);
    per[i][0] = r; per[i][1] = g; per[i][2] = b; per[i][3] = c;
  endtask

  initial begin
    int n, cnt;
    for (int i = 0; i < 3; i++) set_per(i, 10, 10, 10, 10);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", 64'(data_a), 64'd0);
    chk("rst_busy", 64'(busy_v), 64'd0);
    chk("rst_done", 64'(done_v), 64'd0);
    @(negedge clk) rst = 1'b0;

    // All channels at period 10.
    run_pass(0, 841, "t2");
    chk("t2_data", 64'(data_a), model_data(0, 8, 4));
    chk("t2_sat", 64'(sat_a), 64'd0);

    // Filter-keyed periods.
    set_per(0, 4, 5, 10, 2);
    run_pass(0, 841, "t3");
    chk("t3_data", 64'(data_a), {32'd0, 8'd50, 8'd10, 8'd20, 8'd25});
    chk("t3_sat", 64'(sat_a), 64'd0);
    chk("t3_seen_clear", 64'(seen_a10), 64'd1);

    // Reset mid-pass, during the green gate.
    @(negedge clk); start_v[0] = 1'b1;
    @(posedge clk); #1 start_v[0] = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    chk("t1_busy_pre", 64'(busy_v[0]), 64'd1);
    chk("t1_idx_pre", 64'(idx_a), 64'd1);
    chk("t1_code_pre", 64'(code[0]), 64'(2'b11));
    #1 rst = 1'b1;
    #1;
    chk("t1_data", 64'(data_a), 64'd0);
    chk("t1_sat", 64'(sat_a), 64'd0);
    chk("t1_code", 64'(code[0]), 64'd0);
    chk("t1_idx", 64'(idx_a), 64'd0);
    chk("t1_busy", 64'(busy_v[0]), 64'd0);
    chk("t1_done", 64'(done_v[0]), 64'd0);
    @(negedge clk) rst = 1'b0;
    repeat (20) @(posedge clk);
    #1 chk("t1_idle", 64'(busy_v[0]), 64'd0);

    // Randomised periods on the main instance.
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 4; c++) per[0][c] = divs[$urandom_range(0, 6)];
      run_pass(0, 841, "rnd_a");
      chk("rnd_a_data", 64'(data_a), model_data(0, 8, 4));
      chk("rnd_a_sat", 64'(sat_a), model_sat(0, 8, 4));
    end

    // Saturation with a 5-bit counter.
    set_per(1, 2, 2, 2, 2);
    run_pass(1, 841, "t4");
    chk("t4_data", 64'(data_b), {44'd0, 5'd31, 5'd31, 5'd31, 5'd31});
    chk("t4_sat", 64'(sat_b), 64'hf);
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 4; c++) per[1][c] = divs[$urandom_range(0, 6)];
      run_pass(1, 841, "rnd_b");
      chk("rnd_b_data", 64'(data_b), model_data(1, 5, 4));
      chk("rnd_b_sat", 64'(sat_b), model_sat(1, 5, 4));
    end

    // Three-channel build.
    set_per(2, 4, 5, 10, 2);
    run_pass(2, 631, "t6");
    chk("t6_data", 64'(data_c), {40'd0, 8'd10, 8'd20, 8'd25});
    for (int c = 0; c < 3; c++) per[2][c] = divs[$urandom_range(0, 6)];
    run_pass(2, 631, "rnd_c");
    chk("rnd_c_data", 64'(data_c), model_data(2, 8, 3));
    chk("t6_no_clear", 64'(seen_c10), 64'd0);

    // Continuous mode, then drop continuous mid-pass.
    set_per(0, 10, 5, 4, 25);
    @(negedge clk); cont_v[0] = 1'b1; start_v[0] = 1'b1;
    wait_done(0, n);
    chk("t5_first", 64'(n < 2000), 64'd1);
    for (int k = 0; k < 2; k++) begin
      wait_done(0, n);
      chk("t5_period", 64'(n), 64'd841);
      chk("t5_data", 64'(data_a), model_data(0, 8, 4));
    end
    repeat (300) @(posedge clk);
    @(negedge clk); cont_v[0] = 1'b0; start_v[0] = 1'b0;
    cnt = 0;
    repeat (1800) begin
      @(posedge clk); #1;
      if (done_v[0]) cnt++;
    end
    chk("t5_tail_dones", 64'(cnt), 64'd1);
    chk("t5_idle", 64'(busy_v[0]), 64'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
